// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// operand width, funct3 codes, FSM state type and signedness helpers.
package muldiv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   function automatic logic is_signed_a(input logic [2:0] f3);
      return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
   endfunction

   function automatic logic is_signed_b(input logic [2:0] f3);
      return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle between the core and muldiv_unit.
interface muldiv_if;
   import muldiv_pkg::*;

   logic                 start;
   logic [2:0]           funct3;
   logic [XLEN-1:0]      op_a;
   logic [XLEN-1:0]      op_b;
   logic [4:0]           rd_in;
   logic                 abort;
   logic                 busy;
   logic                 done;
   logic [XLEN-1:0]      result;
   logic                 we;
   logic [4:0]           rd_out;

   modport slave (
      input  start, funct3, op_a, op_b, rd_in, abort,
      output busy, done, result, we, rd_out
   );

   modport master (
      output start, funct3, op_a, op_b, rd_in, abort,
      input  busy, done, result, we, rd_out
   );

endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 RV32M multiply/divide unit; one bit per cycle through a shared
// 64-bit shift register, with a single-cycle path for divide special cases.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   muldiv_if.slave   bus
);

   state_t                r_state;
   state_t                w_next;
   logic                  w_accept;

   logic [4:0]            r_cnt;
   logic [2*XLEN-1:0]     r_acc;
   logic [XLEN-1:0]       r_opb;
   logic [2:0]            r_f3;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic [4:0]            r_rd;
   logic [XLEN-1:0]       r_result;
   logic                  r_done;
   logic                  r_we;

   logic                  w_a_neg;
   logic                  w_b_neg;
   logic [XLEN-1:0]       w_mag_a;
   logic [XLEN-1:0]       w_mag_b;
   logic                  w_div_zero;
   logic                  w_div_ovf;
   logic                  w_fast;

   logic [XLEN:0]         w_sum;
   logic [XLEN:0]         w_rem_sh;
   logic [XLEN:0]         w_trial;
   logic [2*XLEN-1:0]     w_step;

   logic [2*XLEN-1:0]     w_prod;
   logic [XLEN-1:0]       w_quo;
   logic [XLEN-1:0]       w_rem;
   logic [XLEN-1:0]       w_res;

   always_comb begin
      w_a_neg    = is_signed_a(bus.funct3) & bus.op_a[XLEN-1];
      w_b_neg    = is_signed_b(bus.funct3) & bus.op_b[XLEN-1];
      w_mag_a    = w_a_neg ? ('0 - bus.op_a) : bus.op_a;
      w_mag_b    = w_b_neg ? ('0 - bus.op_b) : bus.op_b;
      w_div_zero = bus.funct3[2] && (bus.op_b == '0);
      w_div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                   (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
      w_fast     = w_div_zero || w_div_ovf;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               w_accept = 1'b1;
               w_next   = w_fast ? FIN : CALC;
            end
         end
         CALC: begin
            if (bus.abort)
               w_next = IDLE;
            else if (r_cnt == 5'd31)
               w_next = FIN;
         end
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Multiply keeps {hi, multiplier} and shifts right; divide keeps {rem, quotient} and shifts left.
   always_comb begin
      w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
      w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
      w_trial  = w_rem_sh - {1'b0, r_opb};
      if (r_f3[2]) begin
         if (w_trial[XLEN])
            w_step = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
         else
            w_step = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
         w_step = {w_sum, r_acc[XLEN-1:1]};
      end
   end

   always_comb begin
      w_prod = r_neg_q ? ('0 - r_acc) : r_acc;
      w_quo  = r_neg_q ? ('0 - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
      w_rem  = r_neg_r ? ('0 - r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
      unique case (r_f3)
         F3_MUL:                      w_res = w_prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: w_res = w_prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             w_res = w_quo;
         F3_REM, F3_REMU:             w_res = w_rem;
         default:                     w_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opb    <= '0;
         r_f3     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_rd     <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_we     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_we   <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_f3  <= bus.funct3;
                  r_rd  <= bus.rd_in;
                  r_cnt <= '0;
                  // Special divides preload the final {rem, quo} and skip sign correction.
                  if (w_div_zero) begin
                     r_acc   <= {bus.op_a, {XLEN{1'b1}}};
                     r_opb   <= '0;
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                  end else if (w_div_ovf) begin
                     r_acc   <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                     r_opb   <= '0;
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                  end else if (bus.funct3[2]) begin
                     r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                     r_opb   <= w_mag_b;
                     r_neg_q <= w_a_neg ^ w_b_neg;
                     r_neg_r <= w_a_neg;
                  end else begin
                     r_acc   <= {{XLEN{1'b0}}, w_mag_b};
                     r_opb   <= w_mag_a;
                     r_neg_q <= w_a_neg ^ w_b_neg;
                     r_neg_r <= 1'b0;
                  end
               end
            end
            CALC: begin
               if (!bus.abort) begin
                  r_acc <= w_step;
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            FIN: begin
               if (!bus.abort) begin
                  r_result <= w_res;
                  r_done   <= 1'b1;
                  r_we     <= (r_rd != 5'd0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (r_state == CALC) || (r_state == FIN);
   assign bus.done   = r_done;
   assign bus.we     = r_we;
   assign bus.result = r_result;
   assign bus.rd_out = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors with hand-computed
// results, latency tracking, abort/reset/ignored-start scenarios.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk;
   logic rst_n;
   muldiv_if bus();

   muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        we;
      logic [4:0]  rd;
      int          edge_n;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   errors   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && bus.done) begin
         if (q.size() == 0) begin
            n_checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at edge %0d expected no done", cyc);
         end else begin
            e = q.pop_front();
            check({e.name, "_result"}, 64'(bus.result), 64'(e.res));
            check({e.name, "_we"},     64'(bus.we),     64'(e.we));
            check({e.name, "_rd"},     64'(bus.rd_out), 64'(e.rd));
            check({e.name, "_edge"},   64'(cyc),        64'(e.edge_n));
         end
      end
   end

   // Call at a negedge; drives a one-cycle start and optionally records the expected response.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input bit fast,
                        input bit track, input string nm);
      exp_t e;
      bus.start  = 1'b1;
      bus.funct3 = f3;
      bus.op_a   = a;
      bus.op_b   = b;
      bus.rd_in  = rd;
      if (track) begin
         e.res    = exp_res;
         e.we     = (rd != 5'd0);
         e.rd     = rd;
         e.edge_n = cyc + 1 + (fast ? 1 : 33);
         e.name   = nm;
         q.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_checks++;
         errors++;
         $display("FAIL timeout: got %0d pending results expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp_res, input bit fast,
                      input string nm);
      @(negedge clk);
      issue(f3, a, b, rd, exp_res, fast, 1'b1, nm);
      wait_idle();
   endtask

   int busy_n;
   bit seen;

   initial begin
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus.funct3 = '0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      bus.rd_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",   64'(bus.busy),   64'd0);
      check("rst_done",   64'(bus.done),   64'd0);
      check("rst_we",     64'(bus.we),     64'd0);
      check("rst_result", 64'(bus.result), 64'd0);
      check("rst_rd",     64'(bus.rd_out), 64'd0);
      rst_n = 1'b1;

      // MUL with latency and busy-length checks
      @(negedge clk);
      issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 1'b1, "mul_neg");
      busy_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_n++;
         @(negedge clk);
      end
      check("mul_done_seen", 64'(seen),   64'd1);
      check("mul_busy_len",  64'(busy_n), 64'd33);
      @(negedge clk);
      check("done_pulse", 64'(bus.done), 64'd0);
      wait_idle();

      run(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0, "mulhu");
      run(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 1'b0, "mulh");
      run(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd3, 32'hFFFF_FFFF, 1'b0, "mulhsu");
      run(F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, 1'b0, "div_neg");
      run(F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, 1'b0, "rem_neg");
      run(F3_DIV,    32'd7,         32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 1'b0, "div_negb");
      run(F3_REM,    32'd7,         32'hFFFF_FFFE, 5'd8, 32'h0000_0001, 1'b0, "rem_negb");
      run(F3_DIVU,   32'd100,       32'd7,         5'd9, 32'd14,        1'b0, "divu");
      run(F3_REMU,   32'd100,       32'd7,         5'd10, 32'd2,        1'b0, "remu");
      run(F3_DIVU,   32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1'b1, "divu_zero");
      run(F3_REM,    32'd5,         32'd0,         5'd12, 32'd5,        1'b1, "rem_zero");
      run(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1'b1, "div_ovf");
      run(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1'b1, "rem_ovf");

      // start while busy must be ignored
      @(negedge clk);
      issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 1'b1, "mul_ign");
      repeat (3) @(negedge clk);
      issue(F3_DIVU, 32'd9, 32'd3, 5'd20, 32'd0, 1'b0, 1'b0, "ignored");
      wait_idle();
      repeat (40) @(negedge clk);
      check("ign_idle", 64'(bus.busy), 64'd0);

      run(F3_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 1'b0, "mul_rd0");

      // back-to-back: second start lands in the done cycle
      @(negedge clk);
      issue(F3_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 1'b1, "b2b_a");
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("b2b_first_done", 64'(seen), 64'd1);
      issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1'b0, 1'b1, "b2b_b");
      wait_idle();

      // abort in CALC
      @(negedge clk);
      issue(F3_MUL, 32'd5, 32'd5, 5'd6, 32'd0, 1'b0, 1'b0, "abort_calc");
      repeat (8) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_calc_busy",   64'(bus.busy),   64'd0);
      check("abort_calc_done",   64'(bus.done),   64'd0);
      check("abort_calc_result", 64'(bus.result), 64'hFFFF_FFFE);
      repeat (40) @(negedge clk);

      // abort in FIN (fast path)
      issue(F3_DIVU, 32'd5, 32'd0, 5'd7, 32'd0, 1'b1, 1'b0, "abort_fin");
      check("fin_busy", 64'(bus.busy), 64'd1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_fin_done",   64'(bus.done),   64'd0);
      check("abort_fin_busy",   64'(bus.busy),   64'd0);
      check("abort_fin_result", 64'(bus.result), 64'hFFFF_FFFE);
      repeat (5) @(negedge clk);

      // abort overrides start in IDLE
      bus.abort = 1'b1;
      issue(F3_MUL, 32'd2, 32'd2, 5'd8, 32'd0, 1'b0, 1'b0, "abort_idle");
      bus.abort = 1'b0;
      check("abort_idle_busy", 64'(bus.busy), 64'd0);
      repeat (40) @(negedge clk);

      // asynchronous reset mid-operation
      issue(F3_MUL, 32'd9, 32'd9, 5'd9, 32'd0, 1'b0, 1'b0, "reset_mid");
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy",   64'(bus.busy),   64'd0);
      check("rst_mid_result", 64'(bus.result), 64'd0);
      check("rst_mid_rd",     64'(bus.rd_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_mid_idle", 64'(bus.busy), 64'd0);

      run(F3_MUL, 32'd3, 32'd4, 5'd31, 32'd12, 1'b0, "mul_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, n_checks);
      $finish;
   end

endmodule
